// File: rtl/share_collector_pkg.sv
// share_collector_pkg
// Shared types and constants for the share collector:
//   share_pair_t  - one {data, mask} share pair, indexed by DATA_IDX / MASK_IDX
//   byte_share_t  - eight shares of one kind (data byte or mask byte)
//   state_e       - occupancy FSM state of the 2-entry buffer
//   CNT_W_DEFAULT - default width of the accepted-transfer counter
package share_collector_pkg;

  typedef logic [0:1] share_pair_t;

  localparam int unsigned DATA_IDX = 0;
  localparam int unsigned MASK_IDX = 1;

  typedef logic [0:7] byte_share_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/share_fifo2.sv
// share_fifo2
// Two-entry storage with wrap-around read/write pointers. Occupancy is tracked
// by the caller, which must never push when full nor pop when empty.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset; clears pointers and both entries
//   push_i  - write wdata_i into the slot at the write pointer
//   pop_i   - advance the read pointer past the head entry
//   wdata_i - entry to write
//   rdata_o - head entry (slot at the read pointer), straight from flops
module share_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;

  // Pointer next-state: each pointer toggles on its own transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Storage and pointer registers; reset wipes entries so no share lingers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= {W{1'b0}};
      mem_q[1] <= {W{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/share_collector.sv
// share_collector
// Collects eight {data, mask} share pairs into a data byte and a mask byte and
// buffers them in a 2-entry FIFO with valid/ready handshakes on both sides.
// The two share bytes travel in separate flops and are never combined, except
// on the optional debug output.
// Optional feature macro: SHARE_COLLECTOR_UNMASK_EN adds unmasked_o.
// Ports:
//   clk_i, rst_ni     - clock (rising edge), asynchronous active-low reset
//   in_0 .. in_7      - share pairs; [0] data share, [1] mask share
//   valid_i / ready_o - input handshake (ready_o depends on state only)
//   data_o / mask_o   - head entry data byte / mask byte
//   valid_o / ready_i - output handshake
//   cnt_o             - wrapping count of accepted input transfers
//   unmasked_o        - data_o ^ mask_o while valid_o (macro only)
module share_collector
  import share_collector_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [0:1]       in_0,
  input  logic [0:1]       in_1,
  input  logic [0:1]       in_2,
  input  logic [0:1]       in_3,
  input  logic [0:1]       in_4,
  input  logic [0:1]       in_5,
  input  logic [0:1]       in_6,
  input  logic [0:1]       in_7,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [0:7]       data_o,
  output logic [0:7]       mask_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] cnt_o
`ifdef SHARE_COLLECTOR_UNMASK_EN
  ,
  output logic [0:7]       unmasked_o
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer_s;
  logic             out_xfer_s;
  byte_share_t      data_byte_s;
  byte_share_t      mask_byte_s;
  logic [15:0]      wdata_s;
  logic [15:0]      rdata_s;

  // Share k lands on byte bit k; with [0:7] ranges bit 0 is the MSB.
  assign data_byte_s = {in_0[DATA_IDX], in_1[DATA_IDX], in_2[DATA_IDX], in_3[DATA_IDX],
                        in_4[DATA_IDX], in_5[DATA_IDX], in_6[DATA_IDX], in_7[DATA_IDX]};
  assign mask_byte_s = {in_0[MASK_IDX], in_1[MASK_IDX], in_2[MASK_IDX], in_3[MASK_IDX],
                        in_4[MASK_IDX], in_5[MASK_IDX], in_6[MASK_IDX], in_7[MASK_IDX]};
  assign wdata_s     = {data_byte_s, mask_byte_s};

  // Handshake flags are decoded from the state register only, so ready_o has
  // no path from ready_i and the outputs have no path from the inputs.
  assign ready_o    = (state_q != FULL);
  assign valid_o    = (state_q != EMPTY);
  assign in_xfer_s  = valid_i & ready_o;
  assign out_xfer_s = valid_o & ready_i;

  // Occupancy FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer_s) state_d = ONE;
        else           state_d = EMPTY;
      end
      ONE: begin
        if (in_xfer_s && !out_xfer_s)      state_d = FULL;
        else if (!in_xfer_s && out_xfer_s) state_d = EMPTY;
        else                               state_d = ONE;
      end
      FULL: begin
        if (out_xfer_s) state_d = ONE;
        else            state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Accepted-transfer counter next-state; wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (in_xfer_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  share_fifo2 #(
    .W (16)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (in_xfer_s),
    .pop_i   (out_xfer_s),
    .wdata_i (wdata_s),
    .rdata_o (rdata_s)
  );

  assign data_o = rdata_s[15:8];
  assign mask_o = rdata_s[7:0];
  assign cnt_o  = cnt_q;

`ifdef SHARE_COLLECTOR_UNMASK_EN
  // Debug view of the recombined byte, forced to zero when no head entry.
  assign unmasked_o = valid_o ? (data_o ^ mask_o) : 8'h00;
`else
  // No recombination logic in the default build.
`endif

endmodule

// File: tb/tb_share_collector.sv
// tb_share_collector
// Directed self-checking bench for share_collector. A second instance with
// CNT_W=4 shares all stimulus and is used for the counter-wrap check.
// Honours SHARE_COLLECTOR_UNMASK_EN for the unmasked_o checks.
module tb_share_collector;

  logic       clk;
  logic       rst_ni;
  logic [0:1] in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7;
  logic       valid_i;
  logic       ready_i;
  logic       ready_o, valid_o;
  logic [0:7] data_o, mask_o;
  logic [15:0] cnt_o;
  logic       ready4_o, valid4_o;
  logic [0:7] data4_o, mask4_o;
  logic [3:0] cnt4_o;
`ifdef SHARE_COLLECTOR_UNMASK_EN
  logic [0:7] unmasked_o;
  logic [0:7] unmasked4_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  share_collector dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .in_4(in_4), .in_5(in_5), .in_6(in_6), .in_7(in_7),
    .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .mask_o(mask_o),
    .valid_o(valid_o), .ready_i(ready_i),
    .cnt_o(cnt_o)
`ifdef SHARE_COLLECTOR_UNMASK_EN
    , .unmasked_o(unmasked_o)
`endif
  );

  share_collector #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .in_4(in_4), .in_5(in_5), .in_6(in_6), .in_7(in_7),
    .valid_i(valid_i), .ready_o(ready4_o),
    .data_o(data4_o), .mask_o(mask4_o),
    .valid_o(valid4_o), .ready_i(ready_i),
    .cnt_o(cnt4_o)
`ifdef SHARE_COLLECTOR_UNMASK_EN
    , .unmasked_o(unmasked4_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spread a data byte and mask byte over the share pairs: in_k = {d[k], m[k]}.
  task automatic set_in(input logic [0:7] d, input logic [0:7] m);
    in_0 = {d[0], m[0]}; in_1 = {d[1], m[1]};
    in_2 = {d[2], m[2]}; in_3 = {d[3], m[3]};
    in_4 = {d[4], m[4]}; in_5 = {d[5], m[5]};
    in_6 = {d[6], m[6]}; in_7 = {d[7], m[7]};
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst_ni  = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    // Buffer two entries, then pull reset between edges.
    set_in(8'hDE, 8'hAD); valid_i = 1'b1; step();
    set_in(8'hBE, 8'hEF); step();
    valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready: got %b want 1", ready_o); end
    n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL rst_async_data: got %h want 00", data_o); end
    step();
    rst_ni = 1'b1;
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    n_checks++; if (cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", cnt_o); end
    n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", data_o); end
    n_checks++; if (mask_o !== 8'h00) begin n_fail++; $display("FAIL rst_mask: got %h want 00", mask_o); end
  endtask

  task automatic test_single();
    do_reset();
    // ready_i while empty must not disturb anything.
    ready_i = 1'b1; step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL empty_pop_valid: got %b want 0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL empty_pop_ready: got %b want 1", ready_o); end
    set_in(8'hA5, 8'h3C); valid_i = 1'b1; step();
    valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", valid_o); end
    n_checks++; if (data_o !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", data_o); end
    n_checks++; if (mask_o !== 8'h3C) begin n_fail++; $display("FAIL single_mask: got %h want 3c", mask_o); end
    n_checks++; if (cnt_o !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", cnt_o); end
`ifdef SHARE_COLLECTOR_UNMASK_EN
    n_checks++; if (unmasked_o !== 8'h99) begin n_fail++; $display("FAIL single_unmasked: got %h want 99", unmasked_o); end
`endif
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", valid_o); end
`ifdef SHARE_COLLECTOR_UNMASK_EN
    n_checks++; if (unmasked_o !== 8'h00) begin n_fail++; $display("FAIL idle_unmasked: got %h want 00", unmasked_o); end
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(8'h11, 8'h22); valid_i = 1'b1; step();
    set_in(8'h33, 8'h44); step();
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", ready_o); end
    n_checks++; if (cnt_o !== 16'd2) begin n_fail++; $display("FAIL bp_cnt2: got %0d want 2", cnt_o); end
    // Third set offered while full: must be dropped.
    set_in(8'h55, 8'h66); step();
    valid_i = 1'b0;
    n_checks++; if (cnt_o !== 16'd2) begin n_fail++; $display("FAIL bp_no_incr: got %0d want 2", cnt_o); end
    n_checks++; if (data_o !== 8'h11) begin n_fail++; $display("FAIL bp_hold_data: got %h want 11", data_o); end
    n_checks++; if (mask_o !== 8'h22) begin n_fail++; $display("FAIL bp_hold_mask: got %h want 22", mask_o); end
    ready_i = 1'b1; step();
    n_checks++; if (data_o !== 8'h33) begin n_fail++; $display("FAIL bp_second_data: got %h want 33", data_o); end
    n_checks++; if (mask_o !== 8'h44) begin n_fail++; $display("FAIL bp_second_mask: got %h want 44", mask_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", ready_o); end
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0 (third set leaked?)", valid_o); end
  endtask

  task automatic test_stream();
    logic [0:7] d, m;
    do_reset();
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 8'(8'h07 + i * 29);
      m = 8'(8'hF0 - i * 13);
      set_in(d, m);
      step();
      n_checks++; if (valid_o !== 1'b1 || data_o !== d) begin n_fail++; $display("FAIL stream_data[%0d]: got %h v%b want %h", i, data_o, valid_o, d); end
      n_checks++; if (mask_o !== m) begin n_fail++; $display("FAIL stream_mask[%0d]: got %h want %h", i, mask_o, m); end
    end
    valid_i = 1'b0;
    n_checks++; if (cnt_o !== 16'd10) begin n_fail++; $display("FAIL stream_cnt: got %0d want 10", cnt_o); end
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", valid_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_in(8'h01, 8'h02); valid_i = 1'b1; step();
    set_in(8'h0F, 8'hF0); ready_i = 1'b1; step();
    valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || ready_o !== 1'b1) begin n_fail++; $display("FAIL simul_state: got v%b r%b want v1 r1", valid_o, ready_o); end
    n_checks++; if (data_o !== 8'h0F) begin n_fail++; $display("FAIL simul_data: got %h want 0f", data_o); end
    n_checks++; if (mask_o !== 8'hF0) begin n_fail++; $display("FAIL simul_mask: got %h want f0", mask_o); end
    n_checks++; if (cnt_o !== 16'd2) begin n_fail++; $display("FAIL simul_cnt: got %0d want 2", cnt_o); end
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL simul_drain: got %b want 0", valid_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_in(8'(i), 8'(~i));
      step();
    end
    valid_i = 1'b0;
    n_checks++; if (cnt4_o !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt4: got %0d want 1", cnt4_o); end
    n_checks++; if (cnt_o !== 16'd17) begin n_fail++; $display("FAIL wrap_cnt16: got %0d want 17", cnt_o); end
    n_checks++; if (data4_o !== 8'h10) begin n_fail++; $display("FAIL wrap_data4: got %h want 10", data4_o); end
  endtask

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    set_in(8'h00, 8'h00);
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_simultaneous();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/share_collector.md
SHARE_COLLECTOR -- requirements
Module: share_collector

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the accepted-transfer counter.
REQ-002 The port clk_i SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates on its rising edge.
REQ-003 The port rst_ni SHALL be an input, 1 bit wide, and SHALL be the asynchronous, active-low reset.
REQ-004 The ports in_0 .. in_7 SHALL be inputs, 2 bits each ([0:1]); for each share pair, bit [0] is the data share and bit [1] is the mask share.
REQ-005 The port valid_i SHALL be an input, 1 bit wide, indicating that in_0..in_7 carry a complete share set.
REQ-006 The port ready_o SHALL be an output, 1 bit wide, indicating that the block accepts a share set this cycle.
REQ-007 The ports data_o and mask_o SHALL be outputs, 8 bits each ([0:7]), carrying the head entry's data-share byte and mask-share byte.
REQ-008 The port valid_o SHALL be an output, 1 bit wide, indicating that the head entry is valid.
REQ-009 The port ready_i SHALL be an input, 1 bit wide, indicating that the downstream consumer accepts the head entry.
REQ-010 The port cnt_o SHALL be an output, CNT_W bits wide, counting accepted input transfers.
REQ-011 The port unmasked_o SHALL be an output, 8 bits wide ([0:7]), and SHALL exist only when UNMASK_EN is defined.

Function
REQ-012 Unpacking SHALL map in_k[0] to entry data bit k and in_k[1] to entry mask bit k, for k = 0..7.
REQ-013 An input transfer SHALL occur when valid_i=1 and ready_o=1; an output transfer SHALL occur when valid_o=1 and ready_i=1.
REQ-014 Buffering SHALL be a 2-entry FIFO controlled by an FSM with states EMPTY, ONE and FULL.
REQ-015 FSM transitions SHALL be:
- EMPTY to ONE on an input transfer.
- ONE to FULL on an input transfer without an output transfer.
- ONE to EMPTY on an output transfer without an input transfer.
- ONE stays in ONE on simultaneous input and output transfers.
- FULL to ONE on an output transfer.
REQ-016 ready_o SHALL equal 1 exactly when the state is not FULL, with no combinational path from ready_i.
REQ-017 valid_o SHALL equal 1 exactly when the state is not EMPTY.
REQ-018 Latency SHALL be one cycle: data written on edge N appears on data_o/mask_o after edge N, and there is no combinational path from input to output.
REQ-019 data_o and mask_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-020 When the FIFO is FULL, valid_i SHALL be ignored, with no overwrite and no count increment.
REQ-021 When the FIFO is EMPTY, ready_i SHALL be ignored.
REQ-022 FIFO order SHALL be strictly first-in first-out across the read and write pointer wrap-around.
REQ-023 The data share and mask share SHALL always be registered in separate flops and SHALL never be combined in any path except unmasked_o.
REQ-024 cnt_o SHALL increment by 1 on each input transfer and SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-025 Assertion of rst_ni SHALL immediately force the following, independent of clk_i:
- state to EMPTY, and both pointers to 0;
- data_o = 0, mask_o = 0 and cnt_o = 0;
- valid_o = 0 and ready_o = 1.
REQ-026 Reset during buffered traffic SHALL discard all buffered entries without emitting any partial output.
REQ-027 Storage contents SHALL also be cleared on reset, so that no residual share remains in the buffer.

Configuration
REQ-028 Macro SHARE_COLLECTOR_UNMASK_EN: when defined, unmasked_o SHALL equal data_o XOR mask_o combinationally and SHALL be 0 while valid_o=0; it is for debug and verification only.
REQ-029 When SHARE_COLLECTOR_UNMASK_EN is undefined, the unmasked_o port and all XOR logic SHALL be absent, and the remaining behaviour SHALL be unchanged.

Structure
REQ-030 The shared package SHALL hold:
- the share-pair typedef (2 bits, with index constants DATA_IDX=0 and MASK_IDX=1);
- the byte-share typedef;
- the FSM state enum;
- the default value of CNT_W.
REQ-031 The 2-entry storage SHALL be a single sub-module, share_fifo2, instantiated once with 16-bit entries (data byte and mask byte).

Verification
REQ-032 Reset check: hold rst_ni=0 mid-stream, then release with valid_i=0 -> valid_o=0, ready_o=1, cnt_o=0, data_o=0, mask_o=0.
REQ-033 Single transfer: drive in_k={data_k, mask_k} for data byte 0xA5 and mask byte 0x3C, with ready_i=1 -> one cycle later valid_o=1, data_o=0xA5, mask_o=0x3C, and cnt_o=1; with UNMASK_EN, unmasked_o=0x99.
REQ-034 Back-pressure: hold ready_i=0 and send 0x11/0x22 then 0x33/0x44 -> ready_o=0 after the second transfer and a third set is not accepted; raising ready_i then yields 0x11/0x22 followed by 0x33/0x44.
REQ-035 Streaming: send 10 sets back to back with valid_i=1 and ready_i=1 -> one output per cycle in order, and cnt_o=10.
REQ-036 Simultaneous events: in state ONE, apply an input transfer and an output transfer on the same edge -> state stays ONE and the new head is the newly written entry.
REQ-037 Counter wrap: with CNT_W=4, perform 17 transfers -> cnt_o=1.
